// File: rtl/otter_pkg.sv
// Shared control-unit types: FSM states and RV32I major opcodes.
package otter_pkg;

  typedef enum logic [2:0] {
    INIT,
    FETCH,
    EXEC,
    WB,
    INTR
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_MRET = 3'b000;

endpackage

// File: rtl/cu_fsm_if.sv
// Control-unit bundle: decode/ack/interrupt inputs, strobe outputs.
interface cu_fsm_if;

  logic       INTR;
  logic       MIE;
  logic [6:0] OPCODE;
  logic [2:0] FUNC3;
  logic       IMEM_ACK;
  logic       DMEM_ACK;
  logic       RST_OUT;
  logic       PC_WRITE;
  logic       MEM_RDEN1;
  logic       MEM_RDEN2;
  logic       MEM_WE2;
  logic       REG_WRITE;
  logic       CSR_WE;
  logic       INT_TAKEN;
  logic       MRET_EXEC;
  logic       ILLEGAL;

  modport master (
    input  INTR, MIE, OPCODE, FUNC3,
    input  IMEM_ACK, DMEM_ACK,
    output RST_OUT, PC_WRITE,
    output MEM_RDEN1, MEM_RDEN2, MEM_WE2,
    output REG_WRITE, CSR_WE,
    output INT_TAKEN, MRET_EXEC, ILLEGAL
  );

  modport slave (
    output INTR, MIE, OPCODE, FUNC3,
    output IMEM_ACK, DMEM_ACK,
    input  RST_OUT, PC_WRITE,
    input  MEM_RDEN1, MEM_RDEN2, MEM_WE2,
    input  REG_WRITE, CSR_WE,
    input  INT_TAKEN, MRET_EXEC, ILLEGAL
  );

endinterface

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for an asynchronous level input.
module sync_ff #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge CLK) begin
    if (RST) chain <= '0;
    else     chain <= {chain[SYNC_STAGES-2:0], d};
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/cu_fsm.sv
// Multicycle control unit: fetch, execute, writeback and trap entry.
module cu_fsm
  import otter_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input logic      CLK,
  input logic      RST,
  cu_fsm_if.master bus
);

  state_t state;
  state_t next;
  logic   intr_sync;
  logic   done;
  logic   mret;
  logic   int_pending;

  sync_ff #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .CLK(CLK),
    .RST(RST),
    .d  (bus.INTR),
    .q  (intr_sync)
  );

  always_ff @(posedge CLK) begin
    if (RST) state <= INIT;
    else     state <= next;
  end

  // MRET returns from a trap, so it must not immediately re-enter one
  assign int_pending = intr_sync & bus.MIE & ~mret;

  always_comb begin
    next          = state;
    done          = 1'b0;
    mret          = 1'b0;
    bus.RST_OUT   = 1'b0;
    bus.PC_WRITE  = 1'b0;
    bus.MEM_RDEN1 = 1'b0;
    bus.MEM_RDEN2 = 1'b0;
    bus.MEM_WE2   = 1'b0;
    bus.REG_WRITE = 1'b0;
    bus.CSR_WE    = 1'b0;
    bus.INT_TAKEN = 1'b0;
    bus.MRET_EXEC = 1'b0;
    bus.ILLEGAL   = 1'b0;
    unique case (state)
      INIT: begin
        bus.RST_OUT = 1'b1;
        next        = FETCH;
      end
      FETCH: begin
        bus.MEM_RDEN1 = 1'b1;
        if (bus.IMEM_ACK) next = EXEC;
      end
      EXEC: begin
        case (bus.OPCODE)
          OP_LOAD: begin
            bus.MEM_RDEN2 = 1'b1;
            if (bus.DMEM_ACK) next = WB;
          end
          OP_STORE: begin
            bus.MEM_WE2 = 1'b1;
            if (bus.DMEM_ACK) begin
              bus.PC_WRITE = 1'b1;
              done         = 1'b1;
            end
          end
          OP_BRANCH: begin
            bus.PC_WRITE = 1'b1;
            done         = 1'b1;
          end
          OP_LUI, OP_AUIPC, OP_JAL,
          OP_JALR, OP_OP, OP_IMM: begin
            bus.REG_WRITE = 1'b1;
            bus.PC_WRITE  = 1'b1;
            done          = 1'b1;
          end
          OP_SYSTEM: begin
            bus.PC_WRITE = 1'b1;
            done         = 1'b1;
            if (bus.FUNC3 == F3_MRET) begin
              bus.MRET_EXEC = 1'b1;
              mret          = 1'b1;
            end else begin
              bus.CSR_WE    = 1'b1;
              bus.REG_WRITE = 1'b1;
            end
          end
          default: begin
            bus.ILLEGAL  = 1'b1;
            bus.PC_WRITE = 1'b1;
            done         = 1'b1;
          end
        endcase
      end
      WB: begin
        bus.REG_WRITE = 1'b1;
        bus.PC_WRITE  = 1'b1;
        done          = 1'b1;
      end
      INTR: begin
        bus.INT_TAKEN = 1'b1;
        bus.PC_WRITE  = 1'b1;
        next          = FETCH;
      end
      default: next = INIT;
    endcase
    if (done) next = int_pending ? INTR : FETCH;
  end

endmodule

// File: tb/tb_cu_fsm.sv
// Bench for cu_fsm: directed scenarios then random instruction stream
module tb_cu_fsm;

  localparam logic [9:0] V_RST  = 10'b1000000000;
  localparam logic [9:0] V_PC   = 10'b0100000000;
  localparam logic [9:0] V_RD1  = 10'b0010000000;
  localparam logic [9:0] V_RD2  = 10'b0001000000;
  localparam logic [9:0] V_WE2  = 10'b0000100000;
  localparam logic [9:0] V_REG  = 10'b0000010000;
  localparam logic [9:0] V_CSR  = 10'b0000001000;
  localparam logic [9:0] V_INT  = 10'b0000000100;
  localparam logic [9:0] V_MRET = 10'b0000000010;
  localparam logic [9:0] V_ILL  = 10'b0000000001;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] SYSTEM = 7'b1110011;
  localparam logic [6:0] ADDI   = 7'b0010011;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   errors  = 0;

  cu_fsm_if bus ();

  cu_fsm #(
    .SYNC_STAGES(2)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] obs();
    return {bus.RST_OUT, bus.PC_WRITE,
            bus.MEM_RDEN1, bus.MEM_RDEN2,
            bus.MEM_WE2, bus.REG_WRITE,
            bus.CSR_WE, bus.INT_TAKEN,
            bus.MRET_EXEC, bus.ILLEGAL};
  endfunction

  task automatic check(input string tag,
                       input logic [9:0] exp);
    logic [9:0] o;
    @(negedge clk);
    o = obs();
    vectors++;
    assert (o === exp) else begin
      errors++;
      $error("FAIL %s: got %b want %b",
             tag, o, exp);
    end
    @(posedge clk);
    #1;
  endtask

  function automatic bit writes_rd(input logic [6:0] op);
    return op inside {7'b0110111, 7'b0010111,
                      7'b1101111, 7'b1100111,
                      7'b0110011, 7'b0010011};
  endfunction

  // Expected cycle-by-cycle strobes of one instruction, from fetch
  // until the next fetch begins
  task automatic run_instr(input logic [6:0] op,
                           input logic [2:0] f3,
                           input int idly,
                           input int ddly,
                           input logic intr,
                           input logic mie);
    bit is_mret;
    bus.INTR   = intr;
    bus.MIE    = mie;
    bus.OPCODE = op;
    bus.FUNC3  = f3;
    for (int i = 0; i < idly; i++) begin
      bus.IMEM_ACK = (i == idly - 1);
      bus.DMEM_ACK = 1'($urandom);
      check("fetch", V_RD1);
    end
    bus.IMEM_ACK = 1'b0;
    bus.DMEM_ACK = 1'b0;
    is_mret = (op == SYSTEM) && (f3 == 3'b000);
    if (op == LOAD) begin
      for (int j = 0; j < ddly; j++) begin
        bus.DMEM_ACK = (j == ddly - 1);
        bus.IMEM_ACK = 1'($urandom);
        check("load_wait", V_RD2);
      end
      bus.DMEM_ACK = 1'b0;
      bus.IMEM_ACK = 1'b0;
      check("load_wb", V_REG | V_PC);
    end else if (op == STORE) begin
      for (int j = 0; j < ddly; j++) begin
        bus.DMEM_ACK = (j == ddly - 1);
        check("store",
              (j == ddly - 1) ? (V_WE2 | V_PC) : V_WE2);
      end
      bus.DMEM_ACK = 1'b0;
    end else if (op == BRANCH) begin
      check("branch", V_PC);
    end else if (writes_rd(op)) begin
      check("alu", V_REG | V_PC);
    end else if (op == SYSTEM) begin
      if (is_mret) check("mret", V_MRET | V_PC);
      else check("csr", V_CSR | V_REG | V_PC);
    end else begin
      check("illegal", V_ILL | V_PC);
    end
    if (intr && mie && !is_mret) check("trap", V_INT | V_PC);
  endtask

  function automatic logic [6:0] pick_op(input int k);
    case (k)
      0: return LOAD;
      1: return STORE;
      2: return BRANCH;
      3: return 7'b0110111;
      4: return 7'b0010111;
      5: return 7'b1101111;
      6: return 7'b1100111;
      7: return 7'b0110011;
      8: return ADDI;
      9: return SYSTEM;
      default: return 7'b1111111;
    endcase
  endfunction

  initial begin
    rst          = 1'b1;
    bus.INTR     = 1'b0;
    bus.MIE      = 1'b0;
    bus.OPCODE   = '0;
    bus.FUNC3    = '0;
    bus.IMEM_ACK = 1'b0;
    bus.DMEM_ACK = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", V_RST);
    rst = 1'b0;
    check("init", V_RST);

    run_instr(ADDI, 3'b000, 3, 1, 1'b0, 1'b0);
    run_instr(LOAD, 3'b010, 2, 4, 1'b0, 1'b0);
    run_instr(STORE, 3'b010, 2, 3, 1'b1, 1'b1);
    run_instr(SYSTEM, 3'b000, 2, 1, 1'b1, 1'b1);
    run_instr(7'b1111111, 3'b000, 2, 1, 1'b0, 1'b1);
    run_instr(SYSTEM, 3'b001, 2, 1, 1'b1, 1'b0);
    run_instr(BRANCH, 3'b000, 4, 1, 1'b0, 1'b1);

    // Reset in the middle of a load wait
    bus.OPCODE = LOAD;
    bus.INTR   = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.IMEM_ACK = (i == 1);
      check("rst_fetch", V_RD1);
    end
    bus.IMEM_ACK = 1'b0;
    check("rst_wait", V_RD2);
    rst = 1'b1;
    check("rst_wait_edge", V_RD2);
    rst = 1'b0;
    check("rst_mid_load", V_RST);

    for (int n = 0; n < 60; n++) begin
      run_instr(pick_op(int'($urandom_range(0, 10))),
                3'($urandom),
                int'($urandom_range(2, 4)),
                int'($urandom_range(1, 4)),
                1'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
